fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side adapter that drains a synchronous `fifo` with registered read data and presents its contents as a valid/ready stream. It issues `rd_en` pulses, tracks reads in flight across the fixed read latency, and catches returning words in a small credit-managed buffer. Downstream back-pressure never drops data and never creates bubbles. It sits between any `fifo` instance and a streaming consumer such as a packer, serializer or DMA engine.

## Interface
- `WIDTH`, 32: data width; must equal the FIFO `O_WIDTH`.
- `RD_LATENCY`, 1: cycles from an accepted `fifo_rd_en_o` to valid `fifo_rd_data_i`; legal values are 1 and 2.
- `clk_i` in 1: single clock shared with the FIFO.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous discard of buffered and in-flight words.
- `fifo_rd_en_o` out 1: read request to the FIFO.
- `fifo_rd_data_i` in WIDTH: FIFO read data, valid `RD_LATENCY` cycles after an accepted read.
- `fifo_rd_empty_i` in 1: FIFO empty flag.
- `m_valid_o` out 1: stream word available.
- `m_data_o` out WIDTH: stream word.
- `m_ready_i` in 1: consumer accepts the word; a transfer occurs when `m_valid_o & m_ready_i`.
- `level_o` out $clog2(BUF_DEPTH)+1: buffered words plus in-flight words.

## Operation
- Local constant `BUF_DEPTH = RD_LATENCY + 2`, which gives sustained one word per cycle.
- State:
  - `inflight`: shift register of `RD_LATENCY` bits.
  - `buf_cnt`: 0..BUF_DEPTH.
  - Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(BUF_DEPTH) bits. Pointers wrap modulo BUF_DEPTH, including non-power-of-2 depths.
- Issue rule: `fifo_rd_en_o = ~fifo_rd_empty_i & ~flush_i & (buf_cnt + popcount(inflight) < BUF_DEPTH)`.
  - The rule uses registered counts only.
  - There is no combinational path from `m_ready_i` to `fifo_rd_en_o`.
- Each cycle, the issue bit shifts into `inflight[0]`. The word is captured into the buffer at `wr_ptr` when the bit leaves `inflight[RD_LATENCY-1]`.
- `m_valid_o = (buf_cnt != 0)`. `m_data_o` = buffer entry at `rd_ptr`, driven straight from flops.
- Pop on transfer. `buf_cnt` next = `buf_cnt + arrive - pop`. Simultaneous arrive and pop keeps the count and advances both pointers.
- The credit rule guarantees an arrival never meets a full buffer. An overflow is an assertion failure in simulation.
- `flush_i`:
  - Next cycle: `buf_cnt`, pointers and `inflight` are 0, and `m_valid_o` is 0.
  - Data returning from reads issued before the flush is ignored.
  - No read is issued in the flush cycle.
  - A transfer in the flush cycle still completes.

## Timing
- Reset values: `m_valid_o` 0, `m_data_o` 0, `level_o` 0, all counters and pointers 0.
- `fifo_rd_en_o` is combinational. It is 0 in reset because the co-reset FIFO reports empty.
- Latency from first `fifo_rd_en_o` to `m_valid_o` is `RD_LATENCY + 1` cycles, because data is registered into the buffer.
- Throughput is one word per cycle sustained while the FIFO is non-empty and `m_ready_i` is held high.
- When `m_ready_i` drops, reads stop once `level_o == BUF_DEPTH`. At most BUF_DEPTH words are then held.
- Once `m_valid_o` is asserted, it and `m_data_o` stay stable until the transfer; this is the AXI-stream rule.
- If reset asserts mid-operation, all state clears immediately (asynchronously). Buffered and in-flight words are lost.

## Structure
- No shared package is needed. `BUF_DEPTH` and the pointer width are localparams.
- One natural sub-module: `stream_buf`, a parameterised circular register buffer with push, pop, count, head data and clear. `fifo_rd_stream` contains the issue/credit logic, the `inflight` pipe and `level_o`.
- The bench pairs the block with the existing `fifo` (`OUT_REG` = 1, so `RD_LATENCY` = 1) and with a delay-model FIFO for `RD_LATENCY` = 2.

## Test plan
- Fill the FIFO with 0x00..0x0F while `m_ready_i` = 1. Expect 16 transfers on consecutive cycles, the first 2 cycles after the first `rd_en`, with data in order.
- Fill 16 words and hold `m_ready_i` = 0. Expect exactly 3 `rd_en` pulses, `level_o` = 3, and the FIFO retaining 13 words. Release ready and expect the remaining data in order with no loss.
- Toggle `m_ready_i` randomly (50%) over 1000 words, for both `RD_LATENCY` values. Expect the scoreboard to match exactly, with no stability violations and no overflow assertion.
- Assert `flush_i` while `level_o` = 3 with one read in flight. Expect `m_valid_o` = 0 next cycle, the returning word dropped, and normal resumption on the next FIFO word.
- Let the FIFO go empty mid-stream, then write one word. Expect `m_valid_o` to deassert after the last word, then one transfer with the new value.
- Pulse `rst_n_i` low asynchronously mid-burst. Expect all outputs 0 immediately and clean restart after release.

Source files
------------

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
package fifo_rd_stream_pkg;

    localparam int unsigned MIN_RD_LATENCY = 1;
    localparam int unsigned MAX_RD_LATENCY = 2;

    // Two extra entries beyond the read latency let the credit loop sustain one word per cycle.
    function automatic int unsigned buf_depth(input int unsigned rd_latency);
        return rd_latency + 2;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// stream_buf: circular register buffer with push, pop, occupancy count, head data and clear.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   clear_i        : synchronous discard of all entries (wins over push/pop)
//   push_i/push_data_i : write one entry at the tail
//   pop_i          : drop the head entry (caller guarantees the buffer is not empty)
//   head_o         : entry at the read pointer, straight from storage flops
//   valid_o        : registered "buffer not empty"
//   count_o        : number of stored entries, 0..DEPTH
module stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;

    // Pointer increment that wraps at DEPTH, so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for pointers, count and the registered non-empty flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
        valid_d = (cnt_d != '0);
    end

    // State and storage registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign count_o = cnt_q;

    // The upstream credit loop must never push into a full buffer without a pop.
    overflow_chk: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(push_i && !pop_i && !clear_i && (cnt_q == CNT_W'(DEPTH))))
        else $error("stream_buf: push into full buffer");

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-output FIFO and presents its words as a valid/ready stream.
// Ports:
//   clk_i, rst_n_i   : clock shared with the FIFO, asynchronous active-low reset
//   flush_i          : discard buffered and in-flight words; no read is issued this cycle
//   fifo_rd_en_o     : read request (combinational from registered credit state and FIFO empty)
//   fifo_rd_data_i   : FIFO read data, valid RD_LATENCY cycles after an accepted read
//   fifo_rd_empty_i  : FIFO empty flag
//   m_valid_o/m_data_o/m_ready_i : output stream, transfer on valid & ready
//   level_o          : buffered plus in-flight words
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned RD_LATENCY = 1   // legal values 1 and 2
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            flush_i,
    output logic                            fifo_rd_en_o,
    input  logic [WIDTH-1:0]                fifo_rd_data_i,
    input  logic                            fifo_rd_empty_i,
    output logic                            m_valid_o,
    output logic [WIDTH-1:0]                m_data_o,
    input  logic                            m_ready_i,
    output logic [$clog2(RD_LATENCY+2):0]   level_o
);

    localparam int unsigned BUF_DEPTH = buf_depth(RD_LATENCY);
    localparam int unsigned LVL_W     = $clog2(BUF_DEPTH) + 1;

    logic [RD_LATENCY-1:0] inflight_q, inflight_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [LVL_W-1:0]      buf_cnt;
    logic [LVL_W-1:0]      credit_used;
    logic                  issue;
    logic                  pop;
    logic                  arrive;

    // Credit check uses registered counts only, so m_ready_i never reaches fifo_rd_en_o.
    assign credit_used = buf_cnt + LVL_W'($countones(inflight_q));
    assign issue       = ~fifo_rd_empty_i & ~flush_i & (credit_used < LVL_W'(BUF_DEPTH));
    assign pop         = m_valid_o & m_ready_i;
    assign arrive      = inflight_q[RD_LATENCY-1];

    // In-flight pipe and level; an arrival moves a word from in-flight to buffered, leaving level unchanged.
    always_comb begin
        inflight_d    = inflight_q << 1;
        inflight_d[0] = issue;
        level_d       = level_q + LVL_W'(issue) - LVL_W'(pop);
        if (flush_i) begin
            inflight_d = '0;
            level_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= '0;
            level_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            level_q    <= level_d;
        end
    end

    // Returning words land here; flush also discards a word arriving in the flush cycle.
    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (flush_i),
        .push_i      (arrive),
        .push_data_i (fifo_rd_data_i),
        .pop_i       (pop),
        .head_o      (m_data_o),
        .valid_o     (m_valid_o),
        .count_o     (buf_cnt)
    );

    assign fifo_rd_en_o = issue;
    assign level_o      = level_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench: two adapters (read latency 1 and 2) fed from one write stream through FIFO models.
module tb_fifo_rd_stream;

    localparam int unsigned W = 32;
    localparam int MEMSZ = 4096;

    typedef struct {
        logic [31:0] d;
        int          rdy;
    } ent_t;

    typedef struct {
        bit          rdy;
        bit          v0; int l0; bit e0; logic [31:0] d0;
        bit          v1; int l1; bit e1; logic [31:0] d1;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         m_ready;
    logic         rd_en   [2];
    logic         emp_w   [2];
    logic [W-1:0] rd_data [2];
    logic         m_valid [2];
    logic [W-1:0] m_data  [2];
    logic [2:0]   level   [2];

    logic [W-1:0] fmem [MEMSZ];
    int           tail;
    int           h [2];
    logic [W-1:0] stage2;

    int           n_chk, n_fail, cyc;
    ent_t         exq [2][$];
    bit           stab [2];
    logic [W-1:0] stab_d [2];
    int           rx [2], n_en [2];
    int           first_en [2], first_rx [2], last_rx [2];
    logic [W-1:0] first_d [2], last_d [2];
    logic [W-1:0] wseq;
    bit           rand_data;
    vec_t         tbl [9];

    fifo_rd_stream #(.WIDTH(W), .RD_LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .fifo_rd_en_o(rd_en[0]), .fifo_rd_data_i(rd_data[0]), .fifo_rd_empty_i(emp_w[0]),
        .m_valid_o(m_valid[0]), .m_data_o(m_data[0]), .m_ready_i(m_ready), .level_o(level[0]));

    fifo_rd_stream #(.WIDTH(W), .RD_LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .fifo_rd_en_o(rd_en[1]), .fifo_rd_data_i(rd_data[1]), .fifo_rd_empty_i(emp_w[1]),
        .m_valid_o(m_valid[1]), .m_data_o(m_data[1]), .m_ready_i(m_ready), .level_o(level[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] idx(input int i);
        return 12'(i);
    endfunction

    // Co-reset FIFO models: registered output (latency 1) and a two-stage delay (latency 2).
    assign emp_w[0] = !rst_n || (h[0] == tail);
    assign emp_w[1] = !rst_n || (h[1] == tail);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h[0] <= 0; h[1] <= 0;
            rd_data[0] <= '0; rd_data[1] <= '0; stage2 <= '0;
        end else begin
            if (rd_en[0] && !emp_w[0]) begin rd_data[0] <= fmem[idx(h[0])]; h[0] <= h[0] + 1; end
            if (rd_en[1] && !emp_w[1]) begin stage2 <= fmem[idx(h[1])]; h[1] <= h[1] + 1; end
            rd_data[1] <= stage2;
        end
    end

    task automatic chk(input bit ok, input string nm, input int k, input longint act, input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut_l%0d cyc %0d: got %0h expected %0h", nm, k + 1, cyc, act, exp);
        end
    endtask

    // Reference: every word read from the FIFO is owed downstream, in order, no earlier than
    // latency+1 cycles after its read, unless a flush or reset discards it.
    task automatic monitor();
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin exq[k].delete(); stab[k] = 0; end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int   lat;
            bit   emp;
            bit   exp_en;
            ent_t e;
            lat    = k + 1;
            emp    = (h[k] == tail);
            exp_en = !emp && !flush && (exq[k].size() < lat + 2);
            chk(rd_en[k] == exp_en, "rd_en", k, longint'(rd_en[k]), longint'(exp_en));
            chk(int'(level[k]) == exq[k].size(), "level", k, longint'(level[k]), longint'(exq[k].size()));
            if (exq[k].size() > 0 && exq[k][0].rdy <= cyc)
                chk(m_valid[k] == 1'b1, "no_bubble", k, longint'(m_valid[k]), 1);
            if (m_valid[k]) begin
                chk(exq[k].size() > 0 && exq[k][0].rdy <= cyc, "valid_early", k, longint'(exq[k].size()), 1);
                if (exq[k].size() > 0)
                    chk(m_data[k] == exq[k][0].d, "data", k, longint'(m_data[k]), longint'(exq[k][0].d));
            end
            if (stab[k])
                chk(m_valid[k] && m_data[k] == stab_d[k], "stable", k, longint'(m_data[k]), longint'(stab_d[k]));
            if (rd_en[k] && !emp) begin
                e.d   = fmem[idx(h[k])];
                e.rdy = cyc + lat + 1;
                exq[k].push_back(e);
                n_en[k]++;
                if (first_en[k] < 0) first_en[k] = cyc;
            end
            if (m_valid[k] && m_ready) begin
                if (exq[k].size() > 0) void'(exq[k].pop_front());
                rx[k]++;
                last_rx[k] = cyc;
                last_d[k]  = m_data[k];
                if (first_rx[k] < 0) begin first_rx[k] = cyc; first_d[k] = m_data[k]; end
            end
            stab[k]   = m_valid[k] && !m_ready && !flush;
            stab_d[k] = m_data[k];
            if (flush) begin exq[k].delete(); stab[k] = 0; end
        end
    endtask

    // One clock: drive inputs after the rising edge, push writes, sample at the falling edge.
    task automatic cycle(input bit rdy, input bit fl, input int nwr);
        @(posedge clk);
        #1;
        m_ready = rdy;
        flush   = fl;
        for (int i = 0; i < nwr; i++) begin
            fmem[idx(tail)] = rand_data ? $urandom : wseq;
            wseq++;
            tail++;
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        tail = 0; wseq = '0; m_ready = 1'b0; flush = 1'b0; rand_data = 1'b0;
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        #3 rst_n = 1'b1;
    endtask

    task automatic clear_marks();
        for (int k = 0; k < 2; k++) begin first_en[k] = -1; first_rx[k] = -1; end
    endtask

    task automatic chk_all_zero(input string nm);
        for (int k = 0; k < 2; k++) begin
            chk(m_valid[k] == 1'b0, {nm, "_valid"}, k, longint'(m_valid[k]), 0);
            chk(m_data[k] == '0, {nm, "_data"}, k, longint'(m_data[k]), 0);
            chk(level[k] == '0, {nm, "_level"}, k, longint'(level[k]), 0);
            chk(rd_en[k] == 1'b0, {nm, "_rd_en"}, k, longint'(rd_en[k]), 0);
        end
    endtask

    int b0, b1, nw, cnt, n, e0, e1;

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; tail = 0; wseq = '0; rand_data = 1'b0;
        rx[0] = 0; rx[1] = 0; n_en[0] = 0; n_en[1] = 0;
        stab[0] = 0; stab[1] = 0;
        clear_marks();
        flush = 1'b0; m_ready = 1'b0; rst_n = 1'b1;

        //        rdy  v0 l0 e0 d0     v1 l1 e1 d1
        tbl[0] = '{0,  0, 0, 1, 0,     0, 0, 1, 0};
        tbl[1] = '{0,  0, 1, 1, 0,     0, 1, 1, 0};
        tbl[2] = '{0,  1, 2, 1, 0,     0, 2, 1, 0};
        tbl[3] = '{0,  1, 3, 0, 0,     1, 3, 1, 0};
        tbl[4] = '{0,  1, 3, 0, 0,     1, 4, 0, 0};
        tbl[5] = '{0,  1, 3, 0, 0,     1, 4, 0, 0};
        tbl[6] = '{1,  1, 3, 0, 0,     1, 4, 0, 0};
        tbl[7] = '{1,  1, 2, 1, 1,     1, 3, 1, 1};
        tbl[8] = '{1,  1, 2, 1, 2,     1, 3, 1, 2};

        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");

        // Sustained streaming of 16 words with ready held high.
        do_reset();
        clear_marks();
        b0 = rx[0]; b1 = rx[1];
        cycle(1'b1, 1'b0, 16);
        repeat (30) cycle(1'b1, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            chk(first_rx[k] - first_en[k] == k + 2, "first_latency", k, longint'(first_rx[k] - first_en[k]), longint'(k + 2));
            chk(last_rx[k] - first_rx[k] == 15, "back_to_back", k, longint'(last_rx[k] - first_rx[k]), 15);
        end
        chk(rx[0] - b0 == 16, "stream_count", 0, longint'(rx[0] - b0), 16);
        chk(rx[1] - b1 == 16, "stream_count", 1, longint'(rx[1] - b1), 16);

        // Back-pressure: table of per-cycle expectations while ready is held low, then released.
        do_reset();
        b0 = rx[0]; b1 = rx[1]; e0 = n_en[0]; e1 = n_en[1];
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].rdy, 1'b0, (i == 0) ? 16 : 0);
            chk(m_valid[0] == tbl[i].v0, "hold_valid", 0, longint'(m_valid[0]), longint'(tbl[i].v0));
            chk(int'(level[0]) == tbl[i].l0, "hold_level", 0, longint'(level[0]), longint'(tbl[i].l0));
            chk(rd_en[0] == tbl[i].e0, "hold_rd_en", 0, longint'(rd_en[0]), longint'(tbl[i].e0));
            if (tbl[i].v0) chk(m_data[0] == tbl[i].d0, "hold_data", 0, longint'(m_data[0]), longint'(tbl[i].d0));
            chk(m_valid[1] == tbl[i].v1, "hold_valid", 1, longint'(m_valid[1]), longint'(tbl[i].v1));
            chk(int'(level[1]) == tbl[i].l1, "hold_level", 1, longint'(level[1]), longint'(tbl[i].l1));
            chk(rd_en[1] == tbl[i].e1, "hold_rd_en", 1, longint'(rd_en[1]), longint'(tbl[i].e1));
            if (tbl[i].v1) chk(m_data[1] == tbl[i].d1, "hold_data", 1, longint'(m_data[1]), longint'(tbl[i].d1));
            if (i == 5) begin
                chk(n_en[0] - e0 == 3, "hold_reads", 0, longint'(n_en[0] - e0), 3);
                chk(n_en[1] - e1 == 4, "hold_reads", 1, longint'(n_en[1] - e1), 4);
                chk(tail - h[0] == 13, "hold_retained", 0, longint'(tail - h[0]), 13);
                chk(tail - h[1] == 12, "hold_retained", 1, longint'(tail - h[1]), 12);
            end
        end
        repeat (30) cycle(1'b1, 1'b0, 0);
        chk(rx[0] - b0 == 16, "hold_drain", 0, longint'(rx[0] - b0), 16);
        chk(rx[1] - b1 == 16, "hold_drain", 1, longint'(rx[1] - b1), 16);

        // Flush with level 3 on the latency-1 adapter and a read still in flight.
        do_reset();
        cycle(1'b0, 1'b0, 16);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        chk(int'(level[0]) == 3, "flush_pre_level", 0, longint'(level[0]), 3);
        clear_marks();
        cycle(1'b1, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            chk(m_valid[k] == 1'b0, "flush_valid", k, longint'(m_valid[k]), 0);
            chk(level[k] == '0, "flush_level", k, longint'(level[k]), 0);
        end
        cnt = 0;
        while ((first_rx[0] < 0 || first_rx[1] < 0) && cnt < 20) begin
            cycle(1'b1, 1'b0, 0);
            cnt++;
        end
        chk(first_rx[0] >= 0 && first_d[0] == 32'd3, "flush_resume", 0, longint'(first_d[0]), 3);
        chk(first_rx[1] >= 0 && first_d[1] == 32'd3, "flush_resume", 1, longint'(first_d[1]), 3);

        // FIFO runs dry mid-stream, then a single late word.
        do_reset();
        b0 = rx[0]; b1 = rx[1];
        cycle(1'b1, 1'b0, 4);
        repeat (12) cycle(1'b1, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            chk(m_valid[k] == 1'b0, "dry_valid", k, longint'(m_valid[k]), 0);
            chk(level[k] == '0, "dry_level", k, longint'(level[k]), 0);
        end
        wseq = 32'h0000_abcd;
        cycle(1'b1, 1'b0, 1);
        cnt = 0;
        while ((rx[0] - b0 < 5 || rx[1] - b1 < 5) && cnt < 20) begin
            cycle(1'b1, 1'b0, 0);
            cnt++;
        end
        chk(rx[0] - b0 == 5 && last_d[0] == 32'h0000_abcd, "late_word", 0, longint'(last_d[0]), 32'h0000_abcd);
        chk(rx[1] - b1 == 5 && last_d[1] == 32'h0000_abcd, "late_word", 1, longint'(last_d[1]), 32'h0000_abcd);

        // Asynchronous reset in the middle of a burst, then a clean restart.
        do_reset();
        wseq = 32'h0000_0050;
        cycle(1'b1, 1'b0, 16);
        repeat (4) cycle(1'b1, 1'b0, 0);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        tail = 0;
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        #3 rst_n = 1'b1;
        b0 = rx[0]; b1 = rx[1];
        wseq = 32'd100;
        cycle(1'b1, 1'b0, 5);
        cnt = 0;
        while ((rx[0] - b0 < 5 || rx[1] - b1 < 5) && cnt < 30) begin
            cycle(1'b1, 1'b0, 0);
            cnt++;
        end
        chk(rx[0] - b0 == 5 && last_d[0] == 32'd104, "restart", 0, longint'(last_d[0]), 104);
        chk(rx[1] - b1 == 5 && last_d[1] == 32'd104, "restart", 1, longint'(last_d[1]), 104);

        // Random ready and write activity over 1000 words.
        do_reset();
        rand_data = 1'b1;
        b0 = rx[0]; b1 = rx[1]; nw = 0; cnt = 0;
        while ((rx[0] - b0 < 1000 || rx[1] - b1 < 1000) && cnt < 8000) begin
            n = (nw < 1000 && $urandom_range(0, 9) < 7) ? 1 : 0;
            cycle(1'($urandom_range(0, 1)), 1'b0, n);
            nw += n;
            cnt++;
        end
        chk(rx[0] - b0 == 1000, "random_count", 0, longint'(rx[0] - b0), 1000);
        chk(rx[1] - b1 == 1000, "random_count", 1, longint'(rx[1] - b1), 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
